// File: rtl/corexy_pkg.sv
// Shared definitions for the CoreXY move planner.
//   STEP_W    : width of the driver's step-count and speed buses
//   SPEED_SAT : speed value used when a scaled half-period overflows STEP_W
//   state_e   : planner sequencing states
package corexy_pkg;

    localparam int                STEP_W    = 32;
    localparam logic [STEP_W-1:0] SPEED_SAT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        DIV,
        LAUNCH,
        RUN,
        RELEASE
    } state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
//   start    : load dividend/divisor and begin (ignored fields while busy)
//   dividend : DD_W-bit numerator
//   divisor  : DV_W-bit denominator (caller guarantees nonzero)
//   busy     : division in progress
//   done     : high during the final step; quotient is valid from the next cycle
//   quotient : result clipped to STEP_W bits (SPEED_SAT on overflow)
// A division takes exactly DD_W busy cycles. Requires DD_W > STEP_W.
module seq_divider
    import corexy_pkg::*;
#(
    parameter int DD_W = 41,
    parameter int DV_W = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DD_W-1:0]   dividend,
    input  logic [DV_W-1:0]   divisor,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] quotient
);

    localparam int               CNT_W    = $clog2(DD_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DD_W);

    logic [DV_W-1:0]  rem_q, rem_d;
    logic [DV_W-1:0]  dsr_q, dsr_d;
    logic [DD_W-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [DV_W:0]    trial;
    logic [DV_W:0]    diff;

    // quo_q starts as the dividend; its MSB shifts into the partial remainder
    // while quotient bits shift in at the LSB.
    always_comb begin
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        trial  = {rem_q, quo_q[DD_W-1]};
        diff   = trial - {1'b0, dsr_q};
        if (start) begin
            rem_d  = '0;
            dsr_d  = divisor;
            quo_d  = dividend;
            cnt_d  = CNT_INIT;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // remainder stays below the divisor, so it always fits DV_W bits
            if (trial >= {1'b0, dsr_q}) begin
                rem_d = diff[DV_W-1:0];
                quo_d = {quo_q[DD_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DV_W-1:0];
                quo_d = {quo_q[DD_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient = (quo_q[DD_W-1:STEP_W] != '0) ? SPEED_SAT : quo_q[STEP_W-1:0];

endmodule

// File: rtl/corexy_move_planner.sv
// CoreXY move planner: turns Cartesian move commands into motor-space step
// counts (A = dx+dy, B = dx-dy), scales the slower motor's half-period so both
// motors finish together, launches the dual-stepper driver and reports the
// outcome.
//   cmd_*               : command handshake (valid/ready), deltas, dominant half-period
//   stepper_step_in_1/2 : motor A/B step counts (two's complement)
//   stepper_speed_1/2   : motor A/B half-periods in clocks
//   start_driving       : level, high while a move is active
//   steppers_driving    : driver busy
//   stepper_step_out_1/2: driver remaining steps
//   move_done           : one-cycle pulse per retired command
//   move_aborted        : with move_done, remaining step magnitude nonzero
//   remaining_1/2       : driver remaining steps captured at retire
module corexy_move_planner
    import corexy_pkg::*;
#(
    parameter int DELTA_W  = 24,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [DELTA_W-1:0]  cmd_dx,
    input  logic [DELTA_W-1:0]  cmd_dy,
    input  logic [PERIOD_W-1:0] cmd_period,
    output logic [STEP_W-1:0]   stepper_step_in_1,
    output logic [STEP_W-1:0]   stepper_speed_1,
    output logic [STEP_W-1:0]   stepper_step_in_2,
    output logic [STEP_W-1:0]   stepper_speed_2,
    output logic                start_driving,
    input  logic                steppers_driving,
    input  logic [STEP_W-1:0]   stepper_step_out_1,
    input  logic [STEP_W-1:0]   stepper_step_out_2,
    output logic                move_done,
    output logic                move_aborted,
    output logic [STEP_W-1:0]   remaining_1,
    output logic [STEP_W-1:0]   remaining_2
);

    localparam int A_W  = DELTA_W + 1;
    localparam int DD_W = PERIOD_W + DELTA_W + 1;

    state_e                      state_q, state_d;
    logic                        cmd_ready_q, cmd_ready_d;
    logic signed [DELTA_W-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic [PERIOD_W-1:0]         period_q, period_d;
    logic [STEP_W-1:0]           step_1_q, step_1_d, step_2_q, step_2_d;
    logic [STEP_W-1:0]           speed_1_q, speed_1_d, speed_2_q, speed_2_d;
    logic                        sel_1_q, sel_1_d, sel_2_q, sel_2_d;
    logic                        start_q, start_d;
    logic                        done_q, done_d;
    logic                        aborted_q, aborted_d;
    logic [STEP_W-1:0]           rem_1_q, rem_1_d, rem_2_q, rem_2_d;

    logic signed [A_W-1:0]       a, b;
    logic [A_W-1:0]              abs_a, abs_b, dom, oth;
    logic                        a_dom;
    logic [DD_W-1:0]             prod;
    logic                        div_start, div_busy, div_done;
    logic [STEP_W-1:0]           div_quo;

    always_comb begin
        a     = A_W'(dx_q) + A_W'(dy_q);
        b     = A_W'(dx_q) - A_W'(dy_q);
        abs_a = a[A_W-1] ? A_W'(-a) : A_W'(a);
        abs_b = b[A_W-1] ? A_W'(-b) : A_W'(b);
        a_dom = (abs_a >= abs_b);
        dom   = a_dom ? abs_a : abs_b;
        oth   = a_dom ? abs_b : abs_a;
        prod  = DD_W'(period_q) * DD_W'(dom);
    end

    seq_divider #(
        .DD_W (DD_W),
        .DV_W (A_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (prod),
        .divisor  (oth),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        period_d  = period_q;
        step_1_d  = step_1_q;
        step_2_d  = step_2_q;
        speed_1_d = speed_1_q;
        speed_2_d = speed_2_q;
        sel_1_d   = sel_1_q;
        sel_2_d   = sel_2_q;
        start_d   = start_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        rem_1_d   = rem_1_q;
        rem_2_d   = rem_2_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    dx_d     = cmd_dx;
                    dy_d     = cmd_dy;
                    period_d = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
                    state_d  = CALC;
                end
            end
            CALC: begin
                step_1_d = STEP_W'(a);
                step_2_d = STEP_W'(b);
                sel_1_d  = 1'b0;
                sel_2_d  = 1'b0;
                if (dom == '0) begin
                    // the driver ignores zero moves, so retire without launching
                    rem_1_d = '0;
                    rem_2_d = '0;
                    state_d = RELEASE;
                end else if (oth == '0 || oth == dom) begin
                    speed_1_d = STEP_W'(period_q);
                    speed_2_d = STEP_W'(period_q);
                    state_d   = LAUNCH;
                end else begin
                    div_start = 1'b1;
                    if (a_dom) begin
                        speed_1_d = STEP_W'(period_q);
                        sel_2_d   = 1'b1;
                    end else begin
                        speed_2_d = STEP_W'(period_q);
                        sel_1_d   = 1'b1;
                    end
                    state_d = DIV;
                end
            end
            DIV: begin
                if (div_done || !div_busy) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                // hold off while a previous move still keeps the driver busy
                if (!start_q) begin
                    if (!steppers_driving) begin
                        start_d = 1'b1;
                    end
                end else if (steppers_driving) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!steppers_driving) begin
                    rem_1_d = stepper_step_out_1;
                    rem_2_d = stepper_step_out_2;
                    start_d = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // bit 31 is direction only; magnitude decides the abort flag
                done_d    = 1'b1;
                aborted_d = (rem_1_q[STEP_W-2:0] | rem_2_q[STEP_W-2:0]) != '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            step_1_q    <= '0;
            step_2_q    <= '0;
            speed_1_q   <= '0;
            speed_2_q   <= '0;
            sel_1_q     <= 1'b0;
            sel_2_q     <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            rem_1_q     <= '0;
            rem_2_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            step_1_q    <= step_1_d;
            step_2_q    <= step_2_d;
            speed_1_q   <= speed_1_d;
            speed_2_q   <= speed_2_d;
            sel_1_q     <= sel_1_d;
            sel_2_q     <= sel_2_d;
            start_q     <= start_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            rem_1_q     <= rem_1_d;
            rem_2_q     <= rem_2_d;
        end
    end

    // Command operands are only read after a transfer has loaded them.
    always_ff @(posedge clk) begin
        dx_q     <= dx_d;
        dy_q     <= dy_d;
        period_q <= period_d;
    end

    assign cmd_ready         = cmd_ready_q;
    assign stepper_step_in_1 = step_1_q;
    assign stepper_step_in_2 = step_2_q;
    // the non-dominant motor takes the divider's scaled half-period
    assign stepper_speed_1   = sel_1_q ? div_quo : speed_1_q;
    assign stepper_speed_2   = sel_2_q ? div_quo : speed_2_q;
    assign start_driving     = start_q;
    assign move_done         = done_q;
    assign move_aborted      = aborted_q;
    assign remaining_1       = rem_1_q;
    assign remaining_2       = rem_2_q;

endmodule

// File: tb/tb_corexy_move_planner.sv
// Bench for corexy_move_planner: directed commands with hand-computed
// expectations pushed to scoreboard queues; a monitor checks launches and
// retirements; a simple driver model answers start_driving.
module tb_corexy_move_planner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_dx, cmd_dy;
    logic [15:0] cmd_period;
    logic [31:0] stepper_step_in_1, stepper_speed_1, stepper_step_in_2, stepper_speed_2;
    logic        start_driving;
    logic        steppers_driving;
    logic [31:0] stepper_step_out_1, stepper_step_out_2;
    logic        move_done, move_aborted;
    logic [31:0] remaining_1, remaining_2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] s1, s2, sp1, sp2;
        int          xfer;
        int          lat;
    } launch_t;
    typedef struct {
        logic        ab;
        logic [31:0] r1, r2;
        int          xfer;
        int          lat;   // -1: launched move, check release gap instead
    } done_t;
    typedef struct {
        int          len;
        logic [31:0] r1, r2;
    } drv_t;

    launch_t launch_q[$];
    done_t   done_q[$];
    drv_t    drv_q[$];

    corexy_move_planner dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_dx             (cmd_dx),
        .cmd_dy             (cmd_dy),
        .cmd_period         (cmd_period),
        .stepper_step_in_1  (stepper_step_in_1),
        .stepper_speed_1    (stepper_speed_1),
        .stepper_step_in_2  (stepper_step_in_2),
        .stepper_speed_2    (stepper_speed_2),
        .start_driving      (start_driving),
        .steppers_driving   (steppers_driving),
        .stepper_step_out_1 (stepper_step_out_1),
        .stepper_step_out_2 (stepper_step_out_2),
        .move_done          (move_done),
        .move_aborted       (move_aborted),
        .remaining_1        (remaining_1),
        .remaining_2        (remaining_2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver model: goes busy one half-cycle after start_driving rises, stays
    // busy for len cycles (or until start_driving drops), then reports remaining.
    initial begin : drv_model
        drv_t d;
        steppers_driving   = 1'b0;
        stepper_step_out_1 = '0;
        stepper_step_out_2 = '0;
        forever begin
            @(negedge clk);
            if (rst_n && start_driving && !steppers_driving) begin
                if (drv_q.size() > 0) d = drv_q.pop_front();
                else begin
                    d.len = 3;
                    d.r1  = '0;
                    d.r2  = '0;
                end
                steppers_driving = 1'b1;
                for (int i = 0; i < d.len && start_driving; i++) @(negedge clk);
                stepper_step_out_1 = d.r1;
                stepper_step_out_2 = d.r2;
                steppers_driving   = 1'b0;
            end
        end
    end

    logic sd_prev  = 1'b0;
    int   fall_cyc = 0;

    always @(negedge clk) begin : monitor
        launch_t l;
        done_t   d;
        if (start_driving && !sd_prev) begin
            if (launch_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL launch_unexpected: got start_driving=1 expected no launch (cycle %0d)", cyc);
            end else begin
                l = launch_q.pop_front();
                chk("step_in_1", stepper_step_in_1, l.s1);
                chk("step_in_2", stepper_step_in_2, l.s2);
                chk("speed_1", stepper_speed_1, l.sp1);
                chk("speed_2", stepper_speed_2, l.sp2);
                chk("launch_latency", 32'(cyc - l.xfer), 32'(l.lat));
            end
        end
        if (!start_driving && sd_prev) fall_cyc = cyc;
        if (move_done) begin
            if (done_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: got move_done=1 expected none (cycle %0d)", cyc);
            end else begin
                d = done_q.pop_front();
                chk("aborted", {31'b0, move_aborted}, {31'b0, d.ab});
                chk("remaining_1", remaining_1, d.r1);
                chk("remaining_2", remaining_2, d.r2);
                if (d.lat >= 0) begin
                    chk("done_latency", 32'(cyc - d.xfer), 32'(d.lat));
                end else begin
                    chk("release_gap", 32'(cyc - fall_cyc), 32'd1);
                    chk("ready_at_done", {31'b0, cmd_ready}, 32'd1);
                end
            end
        end
        sd_prev = start_driving;
    end

    task automatic send(input logic [23:0] dx, input logic [23:0] dy, input logic [15:0] per,
                        input bit has_l, input launch_t l, input bit has_d, input done_t d,
                        input drv_t dv);
        int w = 0;
        cmd_dx     = dx;
        cmd_dy     = dy;
        cmd_period = per;
        cmd_valid  = 1'b1;
        while (!cmd_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got cmd_ready=0 expected 1");
            cmd_valid = 1'b0;
            return;
        end
        l.xfer = cyc + 1;
        d.xfer = cyc + 1;
        if (has_l) begin
            launch_q.push_back(l);
            drv_q.push_back(dv);
        end
        if (has_d) done_q.push_back(d);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Launched move that runs to completion; r1/r2 are what the driver reports.
    task automatic mv(input logic [23:0] dx, input logic [23:0] dy, input logic [15:0] per,
                      input logic [31:0] s1, input logic [31:0] s2,
                      input logic [31:0] sp1, input logic [31:0] sp2, input int lat,
                      input logic ab, input logic [31:0] r1, input logic [31:0] r2);
        launch_t l;
        done_t   d;
        drv_t    dv;
        l.s1 = s1; l.s2 = s2; l.sp1 = sp1; l.sp2 = sp2; l.xfer = 0; l.lat = lat;
        d.ab = ab; d.r1 = r1; d.r2 = r2; d.xfer = 0; d.lat = -1;
        dv.len = 5; dv.r1 = r1; dv.r2 = r2;
        send(dx, dy, per, 1'b1, l, 1'b1, d, dv);
    endtask

    initial begin : stim
        launch_t l;
        done_t   d;
        drv_t    dv;
        int      w;
        cmd_valid  = 1'b0;
        cmd_dx     = '0;
        cmd_dy     = '0;
        cmd_period = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_start", {31'b0, start_driving}, 32'd0);
        chk("rst_done", {31'b0, move_done}, 32'd0);
        chk("rst_speed_1", stepper_speed_1, 32'd0);
        chk("rst_step_in_2", stepper_step_in_2, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        mv(24'd100, 24'd0, 16'd10, 32'd100, 32'd100, 32'd10, 32'd10, 2, 1'b0, 32'd0, 32'd0);
        mv(24'd100, 24'd50, 16'd10, 32'd150, 32'd50, 32'd10, 32'd30, 43, 1'b0, 32'd0, 32'd0);
        mv(-24'sd30, -24'sd30, 16'd0, 32'hFFFF_FFC4, 32'd0, 32'd1, 32'd1, 2, 1'b0, 32'd0, 32'd0);

        // zero move: retires without launching
        l.s1 = '0; l.s2 = '0; l.sp1 = '0; l.sp2 = '0; l.xfer = 0; l.lat = 0;
        d.ab = 1'b0; d.r1 = '0; d.r2 = '0; d.xfer = 0; d.lat = 2;
        dv.len = 5; dv.r1 = '0; dv.r2 = '0;
        send(24'd0, 24'd0, 16'd5, 1'b0, l, 1'b1, d, dv);

        mv(24'd5, 24'd2, 16'd10, 32'd7, 32'd3, 32'd10, 32'd23, 43, 1'b0, 32'd0, 32'd0);
        mv(24'd5, 24'd3, 16'd4, 32'd8, 32'd2, 32'd4, 32'd16, 43, 1'b1, 32'd20, 32'd0);
        mv(24'd0, 24'd7, 16'd3, 32'd7, 32'hFFFF_FFF9, 32'd3, 32'd3, 2, 1'b0, 32'h8000_0000, 32'd0);
        mv(-24'sd10, 24'd20, 16'd7, 32'd10, 32'hFFFF_FFE2, 32'd21, 32'd7, 43, 1'b1, 32'd0, 32'd5);
        mv(24'h7F_FFFF, 24'h7F_FFFF, 16'hFFFF, 32'h00FF_FFFE, 32'd0, 32'hFFFF, 32'hFFFF, 2,
           1'b0, 32'd0, 32'd0);
        mv(24'h7F_FFFF, -24'sd8388606, 16'hFFFF, 32'd1, 32'h00FF_FFFD, 32'hFFFF_FFFF, 32'hFFFF, 43,
           1'b0, 32'd0, 32'd0);

        // reset while the move is running
        l.s1 = 32'd1; l.s2 = 32'd1; l.sp1 = 32'd2; l.sp2 = 32'd2; l.xfer = 0; l.lat = 2;
        dv.len = 60; dv.r1 = 32'd9; dv.r2 = 32'd9;
        send(24'd1, 24'd0, 16'd2, 1'b1, l, 1'b0, d, dv);
        w = 0;
        while (!(start_driving && steppers_driving) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("run_reached", {31'b0, start_driving && steppers_driving}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_start", {31'b0, start_driving}, 32'd0);
        chk("rst_mid_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, cmd_ready}, 32'd1);
        chk("speed_after_rst", stepper_speed_1, 32'd0);

        mv(24'd100, 24'd0, 16'd10, 32'd100, 32'd100, 32'd10, 32'd10, 2, 1'b0, 32'd0, 32'd0);

        w = 0;
        while ((launch_q.size() != 0 || done_q.size() != 0) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (launch_q.size() != 0 || done_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d launches %0d dones pending expected 0",
                     launch_q.size(), done_q.size());
        end
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
